ifetch_unit: RTL and testbench

- Reads the current `PCVal` and fetches instructions from a variable-latency instruction memory using a req/ack + rvalid handshake.
- Buffers fetched words in a small FIFO that feeds decode, and drives `holdPC` back to the PC so the PC advances only when a fetch is accepted.
- Flushes the FIFO and discards any in-flight response when the pipeline redirects on a branch or jump.
- Sits between the PC and the IF/ID register.

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 tb/tb_ifetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues one outstanding request at a time to the
// instruction memory and queues returned words for decode.
module ifetch_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    output logic          hold_pc,
    input  logic          redirect,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] req_pc;

    logic [DW-1:0] dmem [DEPTH];
    logic [AW-1:0] pmem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rnext;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;

    logic          fire;
    logic          push;
    logic          pop;
    logic [DW-1:0] head_d;
    logic [AW-1:0] head_pc_d;

    // A new fetch only leaves when nothing is in flight and a slot is
    // guaranteed for its response; redirect cycles never issue.
    assign mem_req  = rst & (state == IDLE) & ~redirect
                    & (count < CW'(DEPTH));
    assign mem_addr = pc_in;
    assign fire     = mem_req & mem_ack;
    assign hold_pc  = ~rst | ~(fire | redirect);

    assign push  = (state == WAIT) & mem_rvalid & ~redirect;
    assign pop   = inst_valid & inst_ready & ~redirect;
    assign rnext = rptr + PW'(1);

    // Occupancy and head entry as they will look after this edge.
    always_comb begin
        count_d   = count;
        head_d    = inst;
        head_pc_d = inst_pc;
        unique case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
        if (pop) begin
            if (count > CW'(1)) begin
                head_d    = dmem[rnext];
                head_pc_d = pmem[rnext];
            end else if (push) begin
                head_d    = mem_rdata;
                head_pc_d = req_pc;
            end
        end else if (push && count == '0) begin
            head_d    = mem_rdata;
            head_pc_d = req_pc;
        end
    end

    // Fetch control: track the single outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state  <= WAIT;
                        req_pc <= pc_in;
                    end
                end
                WAIT: begin
                    if (mem_rvalid)
                        state <= IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            dmem[wptr] <= mem_rdata;
            pmem[wptr] <= req_pc;
        end
    end

    // FIFO pointers and registered head outputs; redirect empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (redirect) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rnext;
            count      <= count_d;
            inst_valid <= (count_d != '0);
            inst       <= head_d;
            inst_pc    <= head_pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a queue-based fetch model predicts
// requests and the instruction stream; a monitor checks decode output.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        hold_pc;
    logic        redirect;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch_unit #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .hold_pc    (hold_pc),
        .redirect   (redirect),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // expected decode stream, in order
    ent_t exp_q[$];

    // reference state: PC register, one in-flight fetch, discard flag
    logic [31:0] pc;
    bit          m_out;
    bit          m_disc;
    logic [31:0] m_pc;

    // memory responder
    bit mem_pend;
    int mem_lat;
    bit force_data;

    // stimulus knobs (percentages / latency range)
    int p_ack, p_ready, p_redir, min_lat, max_lat;
    bit use_tgt;
    logic [31:0] tgt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
    endtask

    // one clock: drive at negedge, check requests, advance the model
    task automatic step();
        bit exp_req;
        bit fire;
        bit exp_hold;
        @(negedge clk);
        redirect   = rst && (($urandom % 100) < p_redir);
        mem_ack    = ($urandom % 100) < p_ack;
        inst_ready = ($urandom % 100) < p_ready;
        mem_rvalid = 1'b0;
        if (mem_pend) begin
            if (mem_lat == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = force_data ? 32'h2008_0005 : $urandom;
                force_data = 1'b0;
                mem_pend   = 1'b0;
            end else begin
                mem_lat--;
            end
        end
        pc_in = pc;
        #1;
        exp_req  = rst && !m_out && !redirect
                && (exp_q.size() < DEPTH);
        fire     = exp_req && mem_ack;
        exp_hold = !rst || !(fire || redirect);
        chk("mem_req", mem_req, exp_req);
        chk("hold_pc", hold_pc, exp_hold);
        if (exp_req)
            chk("mem_addr", mem_addr, pc);
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            m_out  = 0;
            m_disc = 0;
            pc     = '0;
        end else begin
            if (m_out) begin
                if (mem_rvalid) begin
                    m_out = 0;
                    if (!m_disc && !redirect)
                        exp_q.push_back('{pc: m_pc, data: mem_rdata});
                end else if (redirect) begin
                    m_disc = 1;
                end
            end
            if (redirect)
                exp_q.delete();
            if (fire) begin
                m_out    = 1;
                m_disc   = 0;
                m_pc     = pc;
                mem_pend = 1;
                mem_lat  = $urandom_range(min_lat, max_lat);
            end
            if (redirect)
                pc = use_tgt ? tgt : (32'($urandom_range(0, 1023)) << 2);
            else if (fire)
                pc = pc + 32'd4;
        end
    endtask

    // monitor: compare every consumed head against the expected stream
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("rst_inst_valid", inst_valid, 1'b0);
            end else begin
                chk("inst_valid", inst_valid, exp_q.size() != 0);
                if (inst_valid && inst_ready && !redirect
                    && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("inst", inst, e.data);
                    chk("inst_pc", inst_pc, e.pc);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0;
        pc = '0; pc_in = '0;
        redirect = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
        inst_ready = 0;
        m_out = 0; m_disc = 0; m_pc = '0;
        mem_pend = 0; mem_lat = 0; force_data = 1;
        use_tgt = 0; tgt = '0;
        p_ack = 100; p_ready = 100; p_redir = 0;
        min_lat = 0; max_lat = 0;

        // reset then first issue
        repeat (3) step();
        #1;
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b1;
        repeat (6) step();

        // back-pressure from PC 0
        use_tgt = 1; tgt = 32'h0; p_redir = 100;
        step();
        p_redir = 0; p_ready = 0;
        repeat (12) step();
        #1;
        chk("bp_valid", inst_valid, 1'b1);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_req", mem_req, 1'b0);
        chk("bp_hold", hold_pc, 1'b1);
        chk("bp_addr", mem_addr, 32'h8);
        p_ready = 100;
        repeat (6) step();

        // redirect while a fetch at 0x10 is pending
        tgt = 32'h10; p_redir = 100;
        step();
        p_redir = 0; min_lat = 2; max_lat = 2;
        step();
        tgt = 32'h40; p_redir = 100;
        step();
        p_redir = 0; p_ack = 0;
        repeat (2) step();
        p_ack = 100; min_lat = 0; max_lat = 0;
        repeat (6) step();
        use_tgt = 0;

        // randomized traffic
        for (int b = 0; b < 15; b++) begin
            p_ack   = $urandom_range(30, 100);
            p_ready = $urandom_range(0, 100);
            p_redir = $urandom_range(0, 20);
            min_lat = 0;
            max_lat = $urandom_range(0, 3);
            repeat (200) step();
        end

        // async reset while a fetch is pending and the FIFO is non-empty
        p_redir = 0; p_ready = 0; p_ack = 100;
        min_lat = 3; max_lat = 3;
        guard = 0;
        while (!(m_out && exp_q.size() > 0) && guard < 40) begin
            step();
            guard++;
        end
        if (guard >= 40)
            chk("wait_timeout", 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 1'b0);
        chk("arst_req", mem_req, 1'b0);
        chk("arst_hold", hold_pc, 1'b1);
        exp_q.delete();
        m_out = 0; m_disc = 0; pc = '0;
        mem_pend = 1; mem_lat = 3;
        p_ack = 0; p_ready = 100;
        repeat (2) step();
        rst = 1'b1;
        repeat (4) step();
        p_ack = 100; min_lat = 0; max_lat = 1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
